book_cmd_scheduler: RTL

BOOK_CMD_SCHEDULER -- requirements
Module: book_cmd_scheduler

---
 rtl/book_cmd_scheduler_pkg.sv | 39 +++
 rtl/book_cmd_scheduler_rr_arb3.sv | 30 +++
 rtl/book_cmd_scheduler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/book_cmd_scheduler_pkg.sv
// Shared constants for the order-book command scheduler: FSM encodings,
// op/side codes, field width and small decode helpers.
package book_pkg;

    localparam int FIELD_W = 16;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_START    = 3'd1;
    localparam logic [2:0] ST_RELEASE  = 3'd2;
    localparam logic [2:0] ST_RESP     = 3'd3;
    localparam logic [2:0] ST_WAIT_LOW = 3'd4;

    localparam logic [1:0] OP_ADD    = 2'd0;
    localparam logic [1:0] OP_CANCEL = 2'd1;
    localparam logic [1:0] OP_MATCH  = 2'd2;

    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        case (idx)
            2'd0:    onehot3 = 3'b001;
            2'd1:    onehot3 = 3'b010;
            2'd2:    onehot3 = 3'b100;
            default: onehot3 = 3'b000;
        endcase
    endfunction

    // Pick requester idx's 16-bit slice out of a packed 3-requester bus.
    function automatic logic [FIELD_W-1:0] field_sel(input logic [3*FIELD_W-1:0] bus,
                                                     input logic [1:0] idx);
        case (idx)
            2'd1:    field_sel = bus[2*FIELD_W-1:FIELD_W];
            2'd2:    field_sel = bus[3*FIELD_W-1:2*FIELD_W];
            default: field_sel = bus[FIELD_W-1:0];
        endcase
    endfunction

endpackage

// File: rtl/book_cmd_scheduler_rr_arb3.sv
// Three-way round-robin arbiter: one-hot grant to the first active request
// found searching upward from ptr+1 (mod 3). Purely combinational.
module rr_arb3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] grant
);

    always_comb begin
        grant = 3'b000;
        case (ptr)
            2'd0: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            2'd1: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/book_cmd_scheduler.sv
// Order-book command scheduler: arbitrates add/cancel/match requesters and
// sequences one command at a time through the book engine handshake.
// Optional engine watchdog enabled by defining BOOK_SCHED_TIMEOUT_EN.
module book_cmd_scheduler
    import book_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req_valid,
    output logic [2:0]  req_ready,
    input  logic [2:0]  req_side,
    input  logic [47:0] req_id,
    input  logic [47:0] req_size,
    input  logic [47:0] req_limit,
    output logic        eng_start,
    output logic [1:0]  eng_op,
    output logic        eng_side,
    output logic [15:0] eng_id,
    output logic [15:0] eng_size,
    output logic [15:0] eng_limit,
    input  logic        eng_done,
    input  logic [15:0] eng_success,
    output logic [2:0]  rsp_valid,
    output logic [15:0] rsp_success,
    output logic        rsp_timeout,
    output logic        busy
);

    logic [2:0] state;
    logic [1:0] ptr;
    logic [2:0] grant;
    logic [1:0] win_idx;
    logic       accept;

    rr_arb3 u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    always_comb begin
        win_idx = 2'd0;
        if (grant[1])      win_idx = 2'd1;
        else if (grant[2]) win_idx = 2'd2;
    end

    // Any pending request in IDLE produces a grant, so it is always taken.
    assign accept    = (state == ST_IDLE) && (|req_valid);
    assign req_ready = ((state == ST_IDLE) && !rst) ? grant : 3'b000;
    assign eng_start = (state == ST_START);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP) ? onehot3(eng_op) : 3'b000;

`ifdef BOOK_SCHED_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        rsp_timeout_q;

    assign rsp_timeout = rsp_timeout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            ptr           <= 2'd2;
            eng_op        <= 2'd0;
            eng_side      <= 1'b0;
            eng_id        <= '0;
            eng_size      <= '0;
            eng_limit     <= '0;
            rsp_success   <= '0;
            rsp_timeout_q <= 1'b0;
            tmo_cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_START;
                        eng_op    <= win_idx;
                        ptr       <= win_idx;
                        eng_side  <= req_side[win_idx];
                        eng_id    <= field_sel(req_id, win_idx);
                        eng_size  <= field_sel(req_size, win_idx);
                        eng_limit <= field_sel(req_limit, win_idx);
                        tmo_cnt   <= '0;
                    end
                end
                ST_START: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (eng_done) begin
                        state         <= ST_RELEASE;
                        rsp_success   <= eng_success;
                        rsp_timeout_q <= 1'b0;
                    end else if (tmo_cnt + 16'd1 == TIMEOUT_CYCLES) begin
                        state <= ST_WAIT_LOW;
                    end
                end
                ST_RELEASE: begin
                    if (!eng_done) state <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                // Engine may complete late; wait for done low before reporting.
                ST_WAIT_LOW: begin
                    if (!eng_done) begin
                        state         <= ST_RESP;
                        rsp_success   <= '0;
                        rsp_timeout_q <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    assign rsp_timeout = 1'b0;

    // TIMEOUT_CYCLES has no effect in this build; the empty block keeps it referenced.
    if (TIMEOUT_CYCLES == 16'd0) begin : g_timeout_unused
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= 2'd2;
            eng_op      <= 2'd0;
            eng_side    <= 1'b0;
            eng_id      <= '0;
            eng_size    <= '0;
            eng_limit   <= '0;
            rsp_success <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_START;
                        eng_op    <= win_idx;
                        ptr       <= win_idx;
                        eng_side  <= req_side[win_idx];
                        eng_id    <= field_sel(req_id, win_idx);
                        eng_size  <= field_sel(req_size, win_idx);
                        eng_limit <= field_sel(req_limit, win_idx);
                    end
                end
                ST_START: begin
                    if (eng_done) begin
                        state       <= ST_RELEASE;
                        rsp_success <= eng_success;
                    end
                end
                ST_RELEASE: begin
                    if (!eng_done) state <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`endif

endmodule
